heap_cmd_scheduler: RTL and testbench

- Upstream command stage for the heap controller.
- Buffers push/pop requests arriving on a valid/ready stream in a small FIFO, then issues them to the heap one at a time via its start/op/key/done handshake.
- Rejects illegal operations (push when full, pop when empty) without touching the heap.
- Returns one response per command, carrying status and the resulting element count.

---
 rtl/heap_pkg.sv | 25 ++
 rtl/heap_cmd_fifo.sv | 57 +++++
 rtl/heap_cmd_scheduler.sv | 145 ++++++++++++++
 tb/tb_heap_cmd_scheduler.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/heap_pkg.sv
// Shared definitions for the heap command path: op codes, response status
// encodings, scheduler state encoding and default widths.
package heap_pkg;

  localparam int KEY_W_DEFAULT = 32;
  localparam int CNT_W_DEFAULT = 10;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  typedef enum logic [1:0] {
    ST_OK        = 2'b00,
    ST_REJ_FULL  = 2'b01,
    ST_REJ_EMPTY = 2'b10,
    ST_TIMEOUT   = 2'b11
  } rsp_status_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/heap_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags. The head word is read
// straight from the storage registers, with no bypass from the write port.
module heap_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("heap_cmd_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      fill;
  logic             do_wr;
  logic             do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign full    = (fill == (AW+1)'(DEPTH));
  assign empty   = (fill == '0);
  assign rd_data = mem[rd_ptr];

  // NOTE: the storage array is deliberately left out of reset; the fill count
  // guarantees no entry is read before it has been written.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      if (do_wr && !do_rd)      fill <= fill + 1'b1;
      else if (!do_wr && do_rd) fill <= fill - 1'b1;
    end
  end

endmodule

// File: rtl/heap_cmd_scheduler.sv
// Command stage in front of the heap: queues push/pop requests, rejects
// illegal ones locally, issues the rest one at a time and answers each.
module heap_cmd_scheduler
  import heap_pkg::*;
#(
  parameter int KEY_W      = KEY_W_DEFAULT,
  parameter int CNT_W      = CNT_W_DEFAULT,
  parameter int HEAP_CAP   = 1023,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic [KEY_W-1:0] cmd_key,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_status,
  output logic             rsp_op,
  output logic [CNT_W-1:0] rsp_count,
  output logic             heap_start,
  output logic             heap_op,
  output logic [KEY_W-1:0] heap_key,
  input  logic             heap_done,
  input  logic [CNT_W-1:0] heap_n,
  output logic             busy
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CAP      = CNT_W'(HEAP_CAP);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  if (HEAP_CAP > (2 ** CNT_W) - 1) begin : g_cap_check
    $error("heap_cmd_scheduler: HEAP_CAP does not fit in CNT_W bits");
  end

  sched_state_e     state;
  logic [CNT_W-1:0] count;
  logic [TMR_W-1:0] timer;
  logic             cur_op;
  logic [KEY_W:0]   head;
  logic             head_op;
  logic [KEY_W-1:0] head_key;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_rd;

  // The FIFO only pops when non-empty, so IDLE can request unconditionally.
  assign fifo_rd   = (state == S_IDLE);
  assign cmd_ready = !fifo_full;
  assign busy      = (state != S_IDLE) || !fifo_empty;
  assign head_op   = head[KEY_W];
  assign head_key  = head[KEY_W-1:0];

  heap_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KEY_W + 1)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (cmd_valid),
    .wr_data ({cmd_op, cmd_key}),
    .rd_en   (fifo_rd),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      count      <= '0;
      timer      <= '0;
      cur_op     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_status <= ST_OK;
      rsp_op     <= 1'b0;
      rsp_count  <= '0;
      heap_start <= 1'b0;
      heap_op    <= 1'b0;
      heap_key   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            cur_op <= head_op;
            if ((head_op == OP_PUSH) && (count == CAP)) begin
              rsp_status <= ST_REJ_FULL;
              rsp_op     <= head_op;
              rsp_count  <= count;
              rsp_valid  <= 1'b1;
              state      <= S_RESP;
            end else if ((head_op == OP_POP) && (count == '0)) begin
              rsp_status <= ST_REJ_EMPTY;
              rsp_op     <= head_op;
              rsp_count  <= count;
              rsp_valid  <= 1'b1;
              state      <= S_RESP;
            end else begin
              // Op and key are launched together with start so the heap
              // samples a consistent command on the ISSUE cycle.
              heap_start <= 1'b1;
              heap_op    <= head_op;
              heap_key   <= head_key;
              state      <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          heap_start <= 1'b0;
          timer      <= '0;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          if (heap_done) begin
            count      <= heap_n;
            rsp_count  <= heap_n;
            rsp_status <= ST_OK;
            rsp_op     <= cur_op;
            rsp_valid  <= 1'b1;
            state      <= S_RESP;
          end else if (timer == TMR_LAST) begin
            rsp_count  <= count;
            rsp_status <= ST_TIMEOUT;
            rsp_op     <= cur_op;
            rsp_valid  <= 1'b1;
            state      <= S_RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_heap_cmd_scheduler.sv
// Bench for heap_cmd_scheduler: two instances (default capacity and a
// capacity of 2), a queue-based response model and a simple heap responder.
module tb_heap_cmd_scheduler;
  import heap_pkg::*;

  localparam int KW  = 32;
  localparam int CW  = 10;
  localparam int TMO = 4096;
  localparam int CAP [2] = '{1023, 2};

  typedef struct packed {
    logic [1:0]    st;
    logic          op;
    logic [CW-1:0] cnt;
  } rsp_t;

  typedef struct packed {
    logic          op;
    logic [KW-1:0] key;
  } iss_t;

  logic          clk;
  logic          reset;
  logic          cmd_valid  [2];
  logic          cmd_ready  [2];
  logic          cmd_op     [2];
  logic [KW-1:0] cmd_key    [2];
  logic          rsp_valid  [2];
  logic          rsp_ready  [2];
  logic [1:0]    rsp_status [2];
  logic          rsp_op     [2];
  logic [CW-1:0] rsp_count  [2];
  logic          heap_start [2];
  logic          heap_op    [2];
  logic [KW-1:0] heap_key   [2];
  logic          heap_done  [2] = '{1'b0, 1'b0};
  logic [CW-1:0] heap_n     [2] = '{'0, '0};
  logic          busy       [2];

  int   errors = 0;
  int   checks = 0;
  rsp_t exp_q [2][$];
  iss_t iss_q [2][$];
  int   mc     [2] = '{0, 0};
  int   hn     [2] = '{0, 0};
  int   dly    [2] = '{0, 0};
  int   starts [2] = '{0, 0};
  int   nrsp   [2] = '{0, 0};
  logic hang   [2] = '{1'b0, 1'b0};
  iss_t held   [2];
  rsp_t last   [2];

  heap_cmd_scheduler #(.HEAP_CAP(1023)) u_dut0 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_op(cmd_op[0]), .cmd_key(cmd_key[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_status(rsp_status[0]),
    .rsp_op(rsp_op[0]), .rsp_count(rsp_count[0]),
    .heap_start(heap_start[0]), .heap_op(heap_op[0]), .heap_key(heap_key[0]),
    .heap_done(heap_done[0]), .heap_n(heap_n[0]), .busy(busy[0])
  );

  heap_cmd_scheduler #(.HEAP_CAP(2)) u_dut1 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_op(cmd_op[1]), .cmd_key(cmd_key[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_status(rsp_status[1]),
    .rsp_op(rsp_op[1]), .rsp_count(rsp_count[1]),
    .heap_start(heap_start[1]), .heap_op(heap_op[1]), .heap_key(heap_key[1]),
    .heap_done(heap_done[1]), .heap_n(heap_n[1]), .busy(busy[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic rsp_t mk_rsp(input logic [1:0] st, input logic op, input int cnt);
    rsp_t r;
    r.st  = st;
    r.op  = op;
    r.cnt = CW'(cnt);
    return r;
  endfunction

  // Model, heap responder and output comparison, all sampled on the falling edge.
  always @(negedge clk) begin : cmp
    rsp_t e;
    iss_t s;
    for (int g = 0; g < 2; g++) begin
      heap_done[g] = 1'b0;
      if (reset) begin
        exp_q[g].delete();
        iss_q[g].delete();
        mc[g]  = 0;
        hn[g]  = 0;
        dly[g] = 0;
      end else begin
        if (dly[g] > 0) begin
          dly[g]--;
          if (dly[g] == 0) begin
            check("heap_op_held", heap_op[g], held[g].op);
            check("heap_key_held", heap_key[g], held[g].key);
            hn[g] = (held[g].op == OP_POP) ? hn[g] - 1 : hn[g] + 1;
            heap_done[g] = 1'b1;
            heap_n[g]    = CW'(hn[g]);
          end
        end
        if (heap_start[g]) begin
          starts[g]++;
          held[g] = '{op: heap_op[g], key: heap_key[g]};
          if (!hang[g]) dly[g] = 2;
          if (iss_q[g].size() == 0) begin
            check("unexpected_heap_start", heap_start[g], 1'b0);
          end else begin
            s = iss_q[g].pop_front();
            check("heap_op", heap_op[g], s.op);
            check("heap_key", heap_key[g], s.key);
          end
        end
        if (rsp_valid[g] && rsp_ready[g]) begin
          last[g] = mk_rsp(rsp_status[g], rsp_op[g], int'(rsp_count[g]));
          nrsp[g]++;
          if (exp_q[g].size() == 0) begin
            check("unexpected_rsp_valid", rsp_valid[g], 1'b0);
          end else begin
            e = exp_q[g].pop_front();
            check("rsp_status", rsp_status[g], e.st);
            check("rsp_op", rsp_op[g], e.op);
            check("rsp_count", rsp_count[g], e.cnt);
          end
        end
        if (cmd_valid[g] && cmd_ready[g]) begin
          if (cmd_op[g] == OP_PUSH && mc[g] == CAP[g]) begin
            exp_q[g].push_back(mk_rsp(ST_REJ_FULL, cmd_op[g], mc[g]));
          end else if (cmd_op[g] == OP_POP && mc[g] == 0) begin
            exp_q[g].push_back(mk_rsp(ST_REJ_EMPTY, cmd_op[g], 0));
          end else begin
            iss_q[g].push_back('{op: cmd_op[g], key: cmd_key[g]});
            if (hang[g]) begin
              exp_q[g].push_back(mk_rsp(ST_TIMEOUT, cmd_op[g], mc[g]));
            end else begin
              mc[g] = (cmd_op[g] == OP_POP) ? mc[g] - 1 : mc[g] + 1;
              exp_q[g].push_back(mk_rsp(ST_OK, cmd_op[g], mc[g]));
            end
          end
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the command.
  task automatic send(input int g, input logic op, input logic [KW-1:0] key);
    int n = 0;
    cmd_valid[g] = 1'b1;
    cmd_op[g]    = op;
    cmd_key[g]   = key;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready[g] && n < 200);
    check("send_cmd_ready", cmd_ready[g], 1'b1);
    @(posedge clk);
    #1;
    cmd_valid[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy[g] || rsp_valid[g]) && n < 6000);
    if (n >= 6000) check("wait_idle_busy", busy[g], 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input int g);
    check("zero_rsp_valid", rsp_valid[g], 1'b0);
    check("zero_rsp_status", rsp_status[g], 2'b00);
    check("zero_rsp_op", rsp_op[g], 1'b0);
    check("zero_rsp_count", rsp_count[g], '0);
    check("zero_heap_start", heap_start[g], 1'b0);
    check("zero_heap_op", heap_op[g], 1'b0);
    check("zero_heap_key", heap_key[g], '0);
    check("zero_busy", busy[g], 1'b0);
    check("zero_cmd_ready", cmd_ready[g], 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int nrsp_before;
    reset = 1'b1;
    for (int g = 0; g < 2; g++) begin
      cmd_valid[g] = 1'b0;
      cmd_op[g]    = 1'b0;
      cmd_key[g]   = '0;
      rsp_ready[g] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_zero(0);
    check_zero(1);

    // Pop on an empty heap: rejected locally, response visible at T+2.
    send(0, OP_POP, '0);
    @(negedge clk);
    check("rej_empty_t1_valid", rsp_valid[0], 1'b0);
    @(negedge clk);
    check("rej_empty_t2_valid", rsp_valid[0], 1'b1);
    check("rej_empty_status", rsp_status[0], ST_REJ_EMPTY);
    check("rej_empty_count", rsp_count[0], 10'd0);
    check("rej_empty_no_start", heap_start[0], 1'b0);
    wait_idle(0);
    check("rej_empty_starts", starts[0], 0);

    // Push 5: one start pulse at T+2 carrying op 0 and key 5, answered OK/1.
    send(0, OP_PUSH, 32'd5);
    @(negedge clk);
    check("push5_t1_start", heap_start[0], 1'b0);
    @(negedge clk);
    check("push5_t2_start", heap_start[0], 1'b1);
    check("push5_op", heap_op[0], 1'b0);
    check("push5_key", heap_key[0], 32'd5);
    @(negedge clk);
    check("push5_start_one_cycle", heap_start[0], 1'b0);
    wait_idle(0);
    check("push5_last", last[0], mk_rsp(ST_OK, OP_PUSH, 1));
    check("push5_starts", starts[0], 1);

    // Capacity 2: third push is rejected full without reaching the heap.
    send(1, OP_PUSH, 32'd3);
    send(1, OP_PUSH, 32'd9);
    send(1, OP_PUSH, 32'd4);
    wait_idle(1);
    check("cap_last", last[1], mk_rsp(ST_REJ_FULL, OP_PUSH, 2));
    check("cap_starts", starts[1], 2);
    check("cap_nrsp", nrsp[1], 3);

    // Stall the response, then fill all FIFO entries behind it.
    rsp_ready[0] = 1'b0;
    send(0, OP_PUSH, 32'd10);
    repeat (6) @(negedge clk);
    check("fill_stalled_valid", rsp_valid[0], 1'b1);
    @(posedge clk);
    #1;
    send(0, OP_PUSH, 32'd20);
    send(0, OP_PUSH, 32'd30);
    send(0, OP_PUSH, 32'd40);
    send(0, OP_PUSH, 32'd50);
    @(negedge clk);
    check("fill_cmd_ready_low", cmd_ready[0], 1'b0);
    check("fill_busy", busy[0], 1'b1);
    @(posedge clk);
    #1;
    rsp_ready[0] = 1'b1;
    wait_idle(0);
    check("fill_last", last[0], mk_rsp(ST_OK, OP_PUSH, 6));
    check("fill_nrsp", nrsp[0], 7);

    // Heap never answers: timeout after TIMEOUT cycles in WAIT, count unchanged.
    hang[0] = 1'b1;
    send(0, OP_PUSH, 32'd77);
    n = 0;
    while (!heap_start[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("tmo_start_seen", heap_start[0], 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid[0] && n < TMO + 50);
    check("tmo_latency", n, TMO + 1);
    check("tmo_status", rsp_status[0], ST_TIMEOUT);
    check("tmo_count", rsp_count[0], 10'd6);
    wait_idle(0);
    hang[0] = 1'b0;
    send(0, OP_POP, '0);
    wait_idle(0);
    check("after_tmo_last", last[0], mk_rsp(ST_OK, OP_POP, 5));

    // Reset while waiting on the heap with two commands queued.
    hang[0] = 1'b1;
    send(0, OP_PUSH, 32'd11);
    send(0, OP_PUSH, 32'd12);
    send(0, OP_PUSH, 32'd13);
    @(negedge clk);
    check("rstwait_busy", busy[0], 1'b1);
    check("rstwait_no_rsp", rsp_valid[0], 1'b0);
    nrsp_before = nrsp[0];
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_zero(0);
    check_zero(1);
    repeat (2) @(posedge clk);
    #1;
    reset   = 1'b0;
    hang[0] = 1'b0;
    send(0, OP_PUSH, 32'd21);
    wait_idle(0);
    check("post_reset_last", last[0], mk_rsp(ST_OK, OP_PUSH, 1));
    check("post_reset_nrsp", nrsp[0], nrsp_before + 1);

    for (int g = 0; g < 2; g++) begin
      check("pending_responses", exp_q[g].size(), 0);
      check("pending_issues", iss_q[g].size(), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
